// File: rtl/machine_config_search.sv
// Exhaustive minimum-press search over button subsets of one machine descriptor.
// NUM_LANES consecutive masks are evaluated per cycle; best = lowest popcount, then lowest mask.
//
// state  | meaning
// IDLE   | waiting for a machine descriptor (in_ready=1)
// SEARCH | evaluating masks base..base+NUM_LANES-1 each cycle
// REPORT | result held on out_* until out_ready
module machine_config_search #(
    parameter int MAX_NUM_LIGHTS  = 16,
    parameter int MAX_NUM_BUTTONS = 13,
    parameter int NUM_LANES       = 4,
    parameter int SUM_WIDTH       = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]                 in_target,
    input  logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]      in_num_buttons,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_buttons,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_found,
    output logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]      out_presses,
    output logic [MAX_NUM_BUTTONS-1:0]                out_mask,
    output logic [SUM_WIDTH-1:0]                      out_total
);
    localparam int NBW = $clog2(MAX_NUM_BUTTONS + 1);
    localparam int BW  = MAX_NUM_BUTTONS + 1;
    localparam int CW  = MAX_NUM_BUTTONS + 2;

    typedef enum logic [1:0] {IDLE, SEARCH, REPORT} state_t;

    state_t                                state_q, state_nxt;
    logic [MAX_NUM_LIGHTS-1:0]             target_q;
    logic [NBW-1:0]                        nb_q;
    logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] buttons_q;
    logic [BW-1:0]                         base_q;
    logic                                  best_found_q;
    logic [NBW-1:0]                        best_pop_q;
    logic [MAX_NUM_BUTTONS-1:0]            best_mask_q;

    logic [CW-1:0]                         limit;
    logic                                  cand_found;
    logic [NBW-1:0]                        cand_pop;
    logic [MAX_NUM_BUTTONS-1:0]            cand_mask;
    logic                                  search_last;
    logic [NBW-1:0]                        nb_clamped;

    assign nb_clamped = (in_num_buttons > NBW'(MAX_NUM_BUTTONS)) ? NBW'(MAX_NUM_BUTTONS) : in_num_buttons;
    assign limit      = CW'(1) << nb_q;
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == REPORT);

    // Lanes fold into the running best in ascending mask order, so ties keep the lower mask.
    always_comb begin
        logic [CW-1:0]             lane_mask;
        logic [MAX_NUM_LIGHTS-1:0] acc;
        logic [NBW-1:0]            pop;
        cand_found = best_found_q;
        cand_pop   = best_pop_q;
        cand_mask  = best_mask_q;
        lane_mask  = '0;
        acc        = '0;
        pop        = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_mask = CW'(base_q) + CW'(l);
            acc       = '0;
            pop       = '0;
            for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
                if (lane_mask[b]) begin
                    acc = acc ^ buttons_q[b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS];
                    pop = pop + NBW'(1);
                end
            end
            if ((lane_mask < limit) && (acc == target_q) &&
                (!cand_found || (pop < cand_pop) ||
                 ((pop == cand_pop) && (lane_mask[MAX_NUM_BUTTONS-1:0] < cand_mask)))) begin
                cand_found = 1'b1;
                cand_pop   = pop;
                cand_mask  = lane_mask[MAX_NUM_BUTTONS-1:0];
            end
        end
    end

    // A zero-popcount match cannot be beaten, so the search can stop there.
    assign search_last = ((CW'(base_q) + CW'(NUM_LANES)) >= limit) ||
                         (cand_found && (cand_pop == '0));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (in_valid)    state_nxt = SEARCH;
            SEARCH:  if (search_last) state_nxt = REPORT;
            REPORT:  if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            nb_q         <= '0;
            buttons_q    <= '0;
            base_q       <= '0;
            best_found_q <= 1'b0;
            best_pop_q   <= '0;
            best_mask_q  <= '0;
            out_found    <= 1'b0;
            out_presses  <= '0;
            out_mask     <= '0;
            out_total    <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        target_q     <= in_target;
                        nb_q         <= nb_clamped;
                        buttons_q    <= in_buttons;
                        base_q       <= '0;
                        best_found_q <= 1'b0;
                        best_pop_q   <= '0;
                        best_mask_q  <= '0;
                    end
                end
                SEARCH: begin
                    best_found_q <= cand_found;
                    best_pop_q   <= cand_pop;
                    best_mask_q  <= cand_mask;
                    if (search_last) begin
                        out_found   <= cand_found;
                        out_presses <= cand_found ? cand_pop : '0;
                        out_mask    <= cand_found ? cand_mask : '0;
                        if (cand_found)
                            out_total <= out_total + SUM_WIDTH'(cand_pop);
                    end else begin
                        base_q <= base_q + BW'(NUM_LANES);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/machine_config_search.md
MACHINE_CONFIG_SEARCH -- requirements
Module: machine_config_search

Interface
REQ-001 The block SHALL have parameter MAX_NUM_LIGHTS, default 16, giving the light vector width.
REQ-002 The block SHALL have parameter MAX_NUM_BUTTONS, default 13, giving the button slots per machine.
REQ-003 The block SHALL have parameter NUM_LANES, default 4, giving masks evaluated per cycle; legal values are powers of two, 1..2^MAX_NUM_BUTTONS.
REQ-004 The block SHALL have parameter SUM_WIDTH, default 32, giving the running-total width.
REQ-005 Port clk  input  1  clock; all logic on the rising edge.
REQ-006 Port rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port in_valid / in_ready  input / output  1 / 1  machine-descriptor handshake.
REQ-008 Port in_target  input  MAX_NUM_LIGHTS  required light pattern; bit i = light i on.
REQ-009 Port in_num_buttons  input  $clog2(MAX_NUM_BUTTONS+1)  count of valid buttons.
REQ-010 Port in_buttons  input  MAX_NUM_BUTTONS*MAX_NUM_LIGHTS  toggle mask of button b at [b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS].
REQ-011 Port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 Port out_found  output  1  1 = target reachable.
REQ-013 Port out_presses  output  $clog2(MAX_NUM_BUTTONS+1)  minimum press count.
REQ-014 Port out_mask  output  MAX_NUM_BUTTONS  chosen button subset; bit b = button b pressed.
REQ-015 Port out_total  output  SUM_WIDTH  sum of out_presses over all found results since reset.

Function
REQ-016 The block SHALL implement states IDLE, SEARCH, REPORT.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 On in_valid&&in_ready, the block SHALL latch all in_* fields, clamp num_buttons to MAX_NUM_BUTTONS, set base=0, clear best, and enter SEARCH.
REQ-019 Each SEARCH cycle SHALL evaluate masks base..base+NUM_LANES-1 and ignore masks >= 2^num_buttons.
REQ-020 A mask SHALL match when the XOR of the selected button vectors equals the latched target.
REQ-021 The best result SHALL be the matching mask with the lowest popcount, with ties resolved to the numerically lowest mask, across lanes and cycles.
REQ-022 The base counter SHALL be MAX_NUM_BUTTONS+1 bits wide and SHALL never wrap.
REQ-023 The block SHALL leave SEARCH after the cycle where base+NUM_LANES >= 2^num_buttons, or earlier after a cycle that records a zero-popcount match.
REQ-024 With num_buttons=0, SEARCH SHALL last one cycle and evaluate mask 0 only.
REQ-025 out_valid SHALL rise the cycle after the final SEARCH cycle, giving latency ceil(2^n/NUM_LANES)+1 cycles from accept.
REQ-026 In REPORT, out_valid SHALL be 1 and out_found, out_presses, out_mask and out_total SHALL be held stable until out_ready.
REQ-027 On out_valid&&out_ready, the block SHALL return to IDLE; a new input SHALL be accepted no earlier than the following cycle.
REQ-028 With no match, the block SHALL report out_found=0, out_presses=0, out_mask=0, and out_total SHALL be unchanged.
REQ-029 out_total SHALL add out_presses when entering REPORT with a match, and SHALL wrap modulo 2^SUM_WIDTH.
REQ-030 Button slots >= num_buttons SHALL never affect the result, whatever their contents.

Reset
REQ-031 While rst_n=0 at a clock edge, state SHALL go to IDLE and in_ready=1.
REQ-032 While rst_n=0 at a clock edge, out_valid, out_found, out_presses, out_mask and out_total SHALL all be 0.
REQ-033 Reset asserted in SEARCH or REPORT SHALL abandon the machine without producing a result; the next accepted machine SHALL be solved correctly.

Verification
REQ-034 Scenario 1: NUM_LANES=4, n=6, target=4'b0110, buttons b0..b5 = 1000,1010,0100,1100,0101,0011 -> out_found=1, out_presses=2, out_mask=0x0A, out_valid 17 cycles after accept.
REQ-035 Scenario 2: target=0, n=5 -> out_found=1, out_presses=0, out_mask=0, out_valid 2 cycles after accept (early exit).
REQ-036 Scenario 3: n=1, b0=0001, target=0010 -> out_found=0, out_presses=0, out_total unchanged.
REQ-037 Scenario 4: Scenario 1, then Scenario 2, with out_ready held low 5 cycles on each -> outputs stable and in_ready=0 while stalled; out_total=2 after each result.
REQ-038 Scenario 5: rst_n pulsed low in the middle of Scenario 1's SEARCH -> no out_valid for that machine; out_total=0; Scenario 1 re-issued gives the REQ-034 result.
REQ-039 Scenario 6: n=3 with garbage in slots 3..MAX_NUM_BUTTONS-1, NUM_LANES=1 and 8 -> identical results, latencies 9 and 2 cycles.
